warp_generator: RTL and testbench
=================================

# warp_generator

Front-end stage of the GPU that sits directly upstream of `warp_dispatcher`. It accepts kernel launch descriptors (total thread count and start PC) through a valid/ready handshake and buffers them in a small FIFO. It splits each launch into warps of at most `WARP_SIZE` threads and emits one `kernel_t` per warp on `valid_kernel`/`kernel_out`. Emission is paced by a credit counter that tracks free SIMD cores, so the dispatcher is never handed a warp it cannot place.

## Interface
- `WARP_SIZE`, default 32: threads per warp; must be a power of 2.
- `NUM_SIMD_CORES`, default 4: initial and maximum credit count.
- `LAUNCH_DEPTH`, default 4: launch FIFO entries; must be a power of 2.
- `THREADS_W`, default 16: width of the launch thread count.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `launch_valid`  in  1  launch descriptor present.
- `launch_threads`  in  `THREADS_W`  total threads in the launch.
- `launch_pc`  in  `PC_W`  kernel start PC.
- `launch_ready`  out  1  FIFO not full; a launch is accepted when `launch_valid & launch_ready`.
- `simd_freed`  in  1  one-cycle pulse, one per SIMD core returned; driven from `is_simd_free`.
- `valid_kernel`  out  1  registered, one-cycle pulse per emitted warp.
- `kernel_out`  out  `kernel_t`  warp descriptor; valid while `valid_kernel` is high.
- `credits`  out  `LOG2_SIMD_CORES+1`  current free-core credit count.
- `busy`  out  1  high when the FSM is in SPLIT or the FIFO is non-empty.

## Operation
- Launch FIFO:
  - A handshake with `launch_threads==0` completes but the launch is dropped; nothing is written.
  - `launch_ready = !full`, and does not depend on `launch_valid`.
- FSM, two states:
  - IDLE: if the FIFO is non-empty, pop the head into the working registers `remaining` and `cur_pc`, then go to SPLIT.
  - SPLIT: when `credits>0`, emit one warp:
    - `thread_count = min(remaining, WARP_SIZE)`
    - `start_pc = cur_pc`
    - `warp_id = next_warp_id`
    - then `remaining -= thread_count`.
  - If `remaining` becomes 0 after an emit, go to IDLE.
  - At most one warp is emitted per cycle.
  - When `credits==0`, hold SPLIT and keep `valid_kernel` low.
- All warps of one launch share the same `start_pc`.
- Warp ID counter:
  - `next_warp_id` is global and is not cleared between launches.
  - It increments by 1 per emitted warp.
  - The value all-ones (`INVALID_WARP_ID`) is reserved: the counter skips it and wraps to 0.
- Credit counter:
  - `credits_next = credits - emit + simd_freed`.
  - A simultaneous emit and free leaves credits unchanged.
  - A `simd_freed` pulse with `credits==NUM_SIMD_CORES` and no emit that cycle is ignored (saturate).
- `thread_count` arithmetic uses `THREADS_W` bits.

## Timing
- Reset values (`rst_n` low, asynchronous):
  - FIFO empty, FSM in IDLE, `credits=NUM_SIMD_CORES`, `next_warp_id=0`.
  - `valid_kernel=0`, `kernel_out.thread_count=0`, `kernel_out.start_pc=0`, `kernel_out.warp_id=INVALID_WARP_ID`.
  - `launch_ready=1`, `busy=0`.
- Reset mid-split discards the FIFO contents and all working state; no partial warp is emitted after `rst_n` rises.
- Latency:
  - Launch accepted at edge E0 into an empty FIFO with the FSM in IDLE.
  - Pop at E1.
  - First `valid_kernel` high in the cycle after E2.
  - Subsequent warps follow back-to-back while `credits>0`.
- Back-to-back launches: the next launch is popped in the cycle following the last warp of the previous launch. This inserts one bubble cycle in IDLE.
- `kernel_out` holds its last value while `valid_kernel` is low.
- FIFO boundaries:
  - A push and pop in the same cycle on a full FIFO is not allowed, because ready is low.
  - A push and pop in the same cycle on a non-full FIFO leaves the count unchanged.

## Structure
- Shared package `Structs_and_Params.svh` holds:
  - `kernel_t` with fields `thread_count`, `start_pc`, `warp_id`;
  - `NUM_SIMD_CORES`, `LOG2_SIMD_CORES`, `WARP_SIZE`, `PC_W`, `WARP_ID_W`;
  - `INVALID_WARP_ID = '1`.
- One sub-module, `launch_fifo`: a synchronous FIFO with pointers one bit wider than the address, and `full`/`empty` outputs.
- The FSM, splitter and credit counter live in the top level.

## Test plan
All scenarios use the parameter defaults (`WARP_SIZE=32`, `NUM_SIMD_CORES=4`, `LAUNCH_DEPTH=4`).
- Reset: assert `rst_n=0` mid-operation -> immediately `valid_kernel=0`, `warp_id=all-ones`, `credits=4`, `launch_ready=1`, and no warp is emitted after release.
- Launch 70 threads at PC `0x100`, no frees -> three consecutive pulses `{32,0x100,0}`, `{32,0x100,1}`, `{6,0x100,2}`; `credits` ends at 1; first pulse two cycles after acceptance.
- Launch 200 threads, no frees -> 4 warps of 32, then stall with `credits=0`. One `simd_freed` pulse -> warp 4 of 32 on the next cycle. A second pulse -> warp 5 of 32. A third pulse -> warp 6 of 8, then IDLE.
- `simd_freed` in the same cycle as an emit -> `credits` unchanged. `simd_freed` with `credits=4` -> stays 4.
- Hold `credits=0` and offer launches every cycle -> exactly 4 accepted into the FIFO beyond the working launch, then `launch_ready=0`. A `0`-thread launch is accepted and produces no warp.
- Preload the warp counter to `INVALID_WARP_ID-1` and emit 2 warps -> IDs `INVALID_WARP_ID-1` then `0`.

Source files
------------

// File: rtl/warp_generator_pkg.sv
// Shared types and parameters for the warp generator front end.
//   kernel_t         : warp descriptor handed to warp_dispatcher
//   gen_state_e      : splitter FSM states
//   INVALID_WARP_ID  : reserved warp ID, never issued by the generator
package warp_generator_pkg;

    localparam int unsigned NUM_SIMD_CORES  = 4;
    localparam int unsigned LOG2_SIMD_CORES = $clog2(NUM_SIMD_CORES);
    localparam int unsigned WARP_SIZE       = 32;
    localparam int unsigned THREADS_W       = 16;
    localparam int unsigned PC_W            = 32;
    localparam int unsigned WARP_ID_W       = 5;

    localparam logic [WARP_ID_W-1:0] INVALID_WARP_ID = '1;

    typedef struct packed {
        logic [THREADS_W-1:0] thread_count;
        logic [PC_W-1:0]      start_pc;
        logic [WARP_ID_W-1:0] warp_id;
    } kernel_t;

    typedef enum logic [0:0] {
        StIdle,
        StSplit
    } gen_state_e;

endpackage

// File: rtl/warp_generator_launch_fifo.sv
// Synchronous launch-descriptor FIFO.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push, push_data  : write request and entry (ignored when full)
//   pop, pop_data    : read request (ignored when empty) and current head
//   full, empty      : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module warp_generator_launch_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once the pointers say so.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/warp_generator.sv
// Splits buffered kernel launches into warps for warp_dispatcher.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   launch_valid/threads/pc/ready       : launch descriptor handshake
//   simd_freed                          : one pulse per SIMD core returned
//   valid_kernel, kernel_out            : registered one-cycle warp pulse + descriptor
//   credits                             : free SIMD core count
//   busy                                : splitting or launches pending
module warp_generator #(
    parameter int unsigned WARP_SIZE      = 32,
    parameter int unsigned NUM_SIMD_CORES = 4,
    parameter int unsigned LAUNCH_DEPTH   = 4,
    parameter int unsigned THREADS_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   launch_valid,
    input  logic [THREADS_W-1:0]                   launch_threads,
    input  logic [warp_generator_pkg::PC_W-1:0]    launch_pc,
    output logic                                   launch_ready,
    input  logic                                   simd_freed,
    output logic                                   valid_kernel,
    output warp_generator_pkg::kernel_t            kernel_out,
    output logic [$clog2(NUM_SIMD_CORES):0]        credits,
    output logic                                   busy
);

    import warp_generator_pkg::*;

    localparam int unsigned CREDIT_W = $clog2(NUM_SIMD_CORES) + 1;
    localparam int unsigned ENTRY_W  = THREADS_W + PC_W;

    logic                 fifo_full, fifo_empty, push, pop;
    logic [ENTRY_W-1:0]   fifo_head;

    gen_state_e           state_q, state_d;
    logic [THREADS_W-1:0] remaining_q, remaining_d, thread_cnt;
    logic [PC_W-1:0]      cur_pc_q, cur_pc_d;
    logic [CREDIT_W-1:0]  credits_q, credits_d;
    logic [WARP_ID_W-1:0] next_id_q, next_id_d, next_id_inc;
    logic                 valid_q, emit;
    kernel_t              kernel_q, kernel_d;

    // Zero-thread launches complete the handshake but are never stored.
    assign launch_ready = !fifo_full;
    assign push         = launch_valid && launch_ready && (launch_threads != '0);

    warp_generator_launch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (LAUNCH_DEPTH)
    ) u_launch_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({launch_threads, launch_pc}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cur_pc_d    = cur_pc_q;
        pop         = 1'b0;
        emit        = 1'b0;
        thread_cnt  = (remaining_q < THREADS_W'(WARP_SIZE)) ? remaining_q
                                                            : THREADS_W'(WARP_SIZE);
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    remaining_d = fifo_head[ENTRY_W-1:PC_W];
                    cur_pc_d    = fifo_head[PC_W-1:0];
                    state_d     = StSplit;
                end
            end
            StSplit: begin
                if (credits_q != '0) begin
                    emit        = 1'b1;
                    remaining_d = remaining_q - thread_cnt;
                    if (remaining_d == '0) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Warp IDs skip the reserved all-ones value.
    assign next_id_inc = next_id_q + WARP_ID_W'(1);

    always_comb begin
        next_id_d = next_id_q;
        kernel_d  = kernel_q;
        if (emit) begin
            next_id_d             = (next_id_inc == INVALID_WARP_ID) ? '0 : next_id_inc;
            kernel_d.thread_count = thread_cnt;
            kernel_d.start_pc     = cur_pc_q;
            kernel_d.warp_id      = next_id_q;
        end
    end

    // A free in the same cycle as an emit cancels out; frees beyond the
    // core count are dropped.
    always_comb begin
        credits_d = credits_q;
        if (emit && !simd_freed) begin
            credits_d = credits_q - CREDIT_W'(1);
        end else if (!emit && simd_freed && (credits_q != CREDIT_W'(NUM_SIMD_CORES))) begin
            credits_d = credits_q + CREDIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            cur_pc_q    <= '0;
            credits_q   <= CREDIT_W'(NUM_SIMD_CORES);
            next_id_q   <= '0;
            valid_q     <= 1'b0;
            kernel_q    <= '{thread_count: '0, start_pc: '0, warp_id: INVALID_WARP_ID};
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cur_pc_q    <= cur_pc_d;
            credits_q   <= credits_d;
            next_id_q   <= next_id_d;
            valid_q     <= emit;
            kernel_q    <= kernel_d;
        end
    end

    assign valid_kernel = valid_q;
    assign kernel_out   = kernel_q;
    assign credits      = credits_q;
    assign busy         = (state_q == StSplit) || !fifo_empty;

endmodule

// File: tb/tb_warp_generator.sv
// Directed bench for warp_generator at default parameters.
module tb_warp_generator;

    import warp_generator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        launch_valid = 1'b0;
    logic [15:0] launch_threads = '0;
    logic [31:0] launch_pc = '0;
    logic        launch_ready;
    logic        simd_freed = 1'b0;
    logic        valid_kernel;
    kernel_t     kernel_out;
    logic [2:0]  credits;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    warp_generator #(
        .WARP_SIZE      (32),
        .NUM_SIMD_CORES (4),
        .LAUNCH_DEPTH   (4),
        .THREADS_W      (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .launch_valid   (launch_valid),
        .launch_threads (launch_threads),
        .launch_pc      (launch_pc),
        .launch_ready   (launch_ready),
        .simd_freed     (simd_freed),
        .valid_kernel   (valid_kernel),
        .kernel_out     (kernel_out),
        .credits        (credits),
        .busy           (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic kernel_t kern(input int unsigned thr, input logic [31:0] pc,
                                     input int unsigned id);
        kern.thread_count = 16'(thr);
        kern.start_pc     = pc;
        kern.warp_id      = 5'(id);
    endfunction

    task automatic check_warp(input string tag, input int unsigned thr, input logic [31:0] pc,
                              input int unsigned id);
        check_eq({tag, "_valid"}, 64'(valid_kernel), 64'(1));
        check_eq({tag, "_kernel"}, 64'(kernel_out), 64'(kern(thr, pc, id)));
    endtask

    task automatic launch(input int unsigned thr, input logic [31:0] pc);
        launch_valid   = 1'b1;
        launch_threads = 16'(thr);
        launch_pc      = pc;
    endtask

    int acc;
    int seen;

    initial begin
        // Reset state
        #12;
        check_eq("rst_valid", 64'(valid_kernel), 64'(0));
        check_eq("rst_kernel", 64'(kernel_out), 64'(kern(0, 32'h0, 31)));
        check_eq("rst_credits", 64'(credits), 64'(4));
        check_eq("rst_ready", 64'(launch_ready), 64'(1));
        check_eq("rst_busy", 64'(busy), 64'(0));
        step();
        rst_n = 1'b1;
        step();

        // 70 threads -> 32, 32, 6; first pulse two edges after acceptance
        launch(70, 32'h100);
        step();
        launch_valid = 1'b0;
        check_eq("l70_e0_valid", 64'(valid_kernel), 64'(0));
        step();
        check_eq("l70_e1_valid", 64'(valid_kernel), 64'(0));
        check_eq("l70_e1_busy", 64'(busy), 64'(1));
        step();
        check_warp("l70_w0", 32, 32'h100, 0);
        check_eq("l70_cr0", 64'(credits), 64'(3));
        step();
        check_warp("l70_w1", 32, 32'h100, 1);
        step();
        check_warp("l70_w2", 6, 32'h100, 2);
        check_eq("l70_cr2", 64'(credits), 64'(1));
        step();
        check_eq("l70_end_valid", 64'(valid_kernel), 64'(0));
        check_eq("l70_hold", 64'(kernel_out), 64'(kern(6, 32'h100, 2)));
        check_eq("l70_end_busy", 64'(busy), 64'(0));

        // Return credits, then one extra free at the ceiling
        simd_freed = 1'b1;
        repeat (3) step();
        check_eq("free_to4", 64'(credits), 64'(4));
        step();
        check_eq("free_sat", 64'(credits), 64'(4));
        simd_freed = 1'b0;

        // 200 threads: 4 warps, stall, then one warp per freed core
        launch(200, 32'h180);
        step();
        launch_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_warp("l200_burst", 32, 32'h180, 3 + i);
        end
        check_eq("l200_cr0", 64'(credits), 64'(0));
        step();
        check_eq("l200_stall_valid", 64'(valid_kernel), 64'(0));
        check_eq("l200_stall_busy", 64'(busy), 64'(1));
        step();
        check_eq("l200_stall2_valid", 64'(valid_kernel), 64'(0));
        simd_freed = 1'b1;
        step();
        simd_freed = 1'b0;
        check_eq("l200_free_cr", 64'(credits), 64'(1));
        step();
        check_warp("l200_w4", 32, 32'h180, 7);
        simd_freed = 1'b1;
        step();
        simd_freed = 1'b0;
        step();
        check_warp("l200_w5", 32, 32'h180, 8);
        simd_freed = 1'b1;
        step();
        simd_freed = 1'b0;
        step();
        check_warp("l200_w6", 8, 32'h180, 9);
        check_eq("l200_w6_cr", 64'(credits), 64'(0));
        step();
        check_eq("l200_idle_busy", 64'(busy), 64'(0));
        simd_freed = 1'b1;
        repeat (4) step();
        simd_freed = 1'b0;
        check_eq("restore_cr", 64'(credits), 64'(4));

        // Free coincident with emit leaves credits unchanged
        launch(64, 32'h200);
        step();
        launch_valid = 1'b0;
        step();
        simd_freed = 1'b1;
        step();
        check_warp("coinc_w0", 32, 32'h200, 10);
        check_eq("coinc_cr0", 64'(credits), 64'(4));
        step();
        check_warp("coinc_w1", 32, 32'h200, 11);
        check_eq("coinc_cr1", 64'(credits), 64'(4));
        simd_freed = 1'b0;
        step();
        check_eq("coinc_end_valid", 64'(valid_kernel), 64'(0));

        // Stall at zero credits and fill the FIFO behind the working launch
        launch(1000, 32'h300);
        step();
        launch_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            check_warp("fill_burst", 32, 32'h300, 12 + i);
        end
        step();
        check_eq("fill_stall_cr", 64'(credits), 64'(0));
        launch(0, 32'h3f0);
        check_eq("zero_ready", 64'(launch_ready), 64'(1));
        step();
        launch_valid = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            launch(33, 32'h600 + 32'(i * 16));
            if (launch_ready) acc++;
            step();
        end
        launch_valid = 1'b0;
        check_eq("fill_accepted", 64'(acc), 64'(4));
        check_eq("fill_ready_low", 64'(launch_ready), 64'(0));
        check_eq("fill_no_warp", 64'(valid_kernel), 64'(0));
        simd_freed = 1'b1;
        step();
        simd_freed = 1'b0;
        step();
        check_warp("pre_rst_w", 32, 32'h300, 16);

        // Asynchronous reset while a warp pulse is on the output
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(valid_kernel), 64'(0));
        check_eq("mid_rst_kernel", 64'(kernel_out), 64'(kern(0, 32'h0, 31)));
        check_eq("mid_rst_credits", 64'(credits), 64'(4));
        check_eq("mid_rst_ready", 64'(launch_ready), 64'(1));
        check_eq("mid_rst_busy", 64'(busy), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_kernel) seen++;
        end
        check_eq("post_rst_no_warp", 64'(seen), 64'(0));
        check_eq("post_rst_busy", 64'(busy), 64'(0));

        // Warp ID wrap past the reserved value, plus a queued second launch
        simd_freed = 1'b1;
        launch(960, 32'h400);
        step();
        launch(64, 32'h500);
        step();
        launch_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check_warp("wrap_run", 32, 32'h400, i);
        end
        step();
        check_eq("wrap_bubble_valid", 64'(valid_kernel), 64'(0));
        check_eq("wrap_bubble_busy", 64'(busy), 64'(1));
        step();
        check_warp("wrap_w30", 32, 32'h500, 30);
        step();
        check_warp("wrap_w0", 32, 32'h500, 0);
        check_eq("wrap_cr", 64'(credits), 64'(4));
        simd_freed = 1'b0;
        step();
        check_eq("wrap_end_valid", 64'(valid_kernel), 64'(0));
        check_eq("wrap_end_busy", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
